// File: rtl/scaler_cfg_ctrl_if.sv
// Geometry request handshake between the host and scaler_cfg_ctrl.
// The host drives a geometry and cfg_valid; the controller answers with cfg_ready.
interface scaler_cfg_ctrl_if #(
  parameter int C_DIM_W = 12
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [C_DIM_W-1:0] cfg_src_width;
  logic [C_DIM_W-1:0] cfg_src_height;
  logic [C_DIM_W-1:0] cfg_dst_width;
  logic [C_DIM_W-1:0] cfg_dst_height;

  modport master (
    output cfg_valid,
    output cfg_src_width,
    output cfg_src_height,
    output cfg_dst_width,
    output cfg_dst_height,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_src_width,
    input  cfg_src_height,
    input  cfg_dst_width,
    input  cfg_dst_height,
    output cfg_ready
  );
endinterface

// File: rtl/scaler_cfg_ctrl.sv
// Scaler geometry controller: computes the x/y ratios with one shared divider.
// The new geometry reaches the scaler's shadow outputs only inside a frame gap.
module scaler_cfg_ctrl #(
  parameter int C_DIM_W       = 12,
  parameter int C_FRAC_W      = 16,
  parameter int C_RATIO_W     = C_DIM_W + C_FRAC_W,
  parameter int C_DEF_SRC_W   = 640,
  parameter int C_DEF_SRC_H   = 480,
  parameter int C_DEF_DST_W   = 1024,
  parameter int C_DEF_DST_H   = 768,
  parameter int C_DEF_X_RATIO = 40960,
  parameter int C_DEF_Y_RATIO = 40960
) (
  input  logic                 clk_in1,
  input  logic                 rst_n,
  scaler_cfg_ctrl_if.slave     cfg,
  input  logic                 per_img_vsync,
  output logic [C_DIM_W-1:0]   src_img_width,
  output logic [C_DIM_W-1:0]   src_img_height,
  output logic [C_DIM_W-1:0]   dst_img_width,
  output logic [C_DIM_W-1:0]   dst_img_height,
  output logic [C_RATIO_W-1:0] x_ratio,
  output logic [C_RATIO_W-1:0] y_ratio,
  output logic                 cfg_busy,
  output logic                 cfg_update,
  output logic                 cfg_err
);

  localparam int REM_W = C_DIM_W + 1;
  localparam int TRY_W = C_DIM_W + 2;
  localparam int CNT_W = $clog2(C_RATIO_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_RATIO_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    DIV_X,
    DIV_Y,
    PEND
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [C_DIM_W-1:0]   cap_src_w;
  logic [C_DIM_W-1:0]   cap_src_h;
  logic [C_DIM_W-1:0]   cap_dst_w;
  logic [C_DIM_W-1:0]   cap_dst_h;
  logic [C_RATIO_W-1:0] pend_x;
  logic [C_RATIO_W-1:0] pend_y;

  logic [REM_W-1:0]     rem;
  logic [C_RATIO_W-1:0] dvd;
  logic [CNT_W-1:0]     cnt;
  logic                 vsync_d;

  logic                 accept;
  logic                 dim_zero;
  logic                 div_run;
  logic                 div_last;
  logic                 gap;
  logic [C_DIM_W-1:0]   divisor;
  logic [TRY_W-1:0]     trial;
  logic                 ge;
  logic [REM_W-1:0]     rem_nxt;
  logic [C_RATIO_W-1:0] q_nxt;

  assign accept   = cfg.cfg_valid && (state == IDLE);
  assign dim_zero = (cfg.cfg_src_width  == '0) ||
                    (cfg.cfg_src_height == '0) ||
                    (cfg.cfg_dst_width  == '0) ||
                    (cfg.cfg_dst_height == '0);
  assign div_run  = (state == DIV_X) || (state == DIV_Y);
  assign div_last = (cnt == CNT_LAST);
  assign gap      = !per_img_vsync && !vsync_d;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    divisor = (state == DIV_Y) ? cap_dst_h : cap_dst_w;
    trial   = {rem, dvd[C_RATIO_W-1]};
    ge      = (trial >= {2'b00, divisor});
    rem_nxt = ge ? REM_W'(trial - {2'b00, divisor})
                 : trial[REM_W-1:0];
    q_nxt   = {dvd[C_RATIO_W-2:0], ge};
  end

  // State register.
  always_ff @(posedge clk_in1 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = dim_zero ? ERR : DIV_X;
      ERR:   state_nxt = IDLE;
      DIV_X: if (div_last) state_nxt = DIV_Y;
      DIV_Y: if (div_last) state_nxt = PEND;
      PEND:  if (gap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs follow the state directly.
  always_comb begin
    cfg.cfg_ready = (state == IDLE);
    cfg_busy      = (state != IDLE);
  end

  // Request capture and the shared divider datapath.
  always_ff @(posedge clk_in1 or negedge rst_n) begin
    if (!rst_n) begin
      cap_src_w <= '0;
      cap_src_h <= '0;
      cap_dst_w <= '0;
      cap_dst_h <= '0;
      pend_x    <= '0;
      pend_y    <= '0;
      rem       <= '0;
      dvd       <= '0;
      cnt       <= '0;
    end else if (accept) begin
      cap_src_w <= cfg.cfg_src_width;
      cap_src_h <= cfg.cfg_src_height;
      cap_dst_w <= cfg.cfg_dst_width;
      cap_dst_h <= cfg.cfg_dst_height;
      rem       <= '0;
      dvd       <= {cfg.cfg_src_width, {C_FRAC_W{1'b0}}};
      cnt       <= '0;
    end else if (div_run) begin
      if (div_last) begin
        cnt <= '0;
        rem <= '0;
        if (state == DIV_X) begin
          pend_x <= q_nxt;
          dvd    <= {cap_src_h, {C_FRAC_W{1'b0}}};
        end else begin
          pend_y <= q_nxt;
          dvd    <= q_nxt;
        end
      end else begin
        cnt <= cnt + 1'b1;
        rem <= rem_nxt;
        dvd <= q_nxt;
      end
    end
  end

  // Shadow outputs load together in a frame gap; error flag is sticky.
  always_ff @(posedge clk_in1 or negedge rst_n) begin
    if (!rst_n) begin
      src_img_width  <= C_DIM_W'(C_DEF_SRC_W);
      src_img_height <= C_DIM_W'(C_DEF_SRC_H);
      dst_img_width  <= C_DIM_W'(C_DEF_DST_W);
      dst_img_height <= C_DIM_W'(C_DEF_DST_H);
      x_ratio        <= C_RATIO_W'(C_DEF_X_RATIO);
      y_ratio        <= C_RATIO_W'(C_DEF_Y_RATIO);
      cfg_update     <= 1'b0;
      cfg_err        <= 1'b0;
      vsync_d        <= 1'b0;
    end else begin
      vsync_d    <= per_img_vsync;
      cfg_update <= 1'b0;
      if (accept) cfg_err <= 1'b0;
      else if (state == ERR) cfg_err <= 1'b1;
      if ((state == PEND) && gap) begin
        src_img_width  <= cap_src_w;
        src_img_height <= cap_src_h;
        dst_img_width  <= cap_dst_w;
        dst_img_height <= cap_dst_h;
        x_ratio        <= pend_x;
        y_ratio        <= pend_y;
        cfg_update     <= 1'b1;
      end
    end
  end

endmodule
